// File: rtl/coder_interleaver_ctrl.sv
// coder_interleaver_ctrl: streams one code block into the turbo interleaver and streams the permuted block back out
module coder_interleaver_ctrl #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          k_eq_6144_in,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [6143:0] il_cin,
  output logic          il_k_eq_6144,
  input  logic [6143:0] il_cout
);
  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, UNLOAD} state_t;
  state_t        r_state;
  state_t        w_next;
  logic [6143:0] r_stage;
  logic [6143:0] r_outbuf;
  logic          r_k;
  logic          r_done;
  logic [9:0]    r_cnt;
  logic [9:0]    w_last;
  logic          w_last_beat;
  logic          w_in_hs;
  logic          w_out_hs;
  assign w_last      = r_k ? 10'(6144 / W - 1) : 10'(1056 / W - 1);
  assign w_last_beat = r_cnt == w_last;
  assign w_in_hs     = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next-state: LOAD and UNLOAD each end on the Nth handshake; CAPTURE is a single cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = (w_in_hs && w_last_beat) ? CAPTURE : LOAD;
      CAPTURE: w_next = UNLOAD;
      UNLOAD:  w_next = (w_out_hs && w_last_beat) ? IDLE : UNLOAD;
      default: w_next = IDLE;
    endcase
  end
  // Outputs: handshakes from state, interleaver driven straight from registers
  always_comb begin
    in_ready     = r_state == LOAD;
    out_valid    = r_state == UNLOAD;
    busy         = r_state != IDLE;
    done         = r_done;
    out_data     = r_outbuf[6143 -: W];
    il_cin       = r_stage;
    il_k_eq_6144 = r_k;
  end
  // Datapath: shift-in staging, top-aligned capture of the permuted block, shift-out buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage  <= '0;
      r_outbuf <= '0;
      r_k      <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_out_hs && w_last_beat;
      if (r_state == IDLE && start) begin
        r_k     <= k_eq_6144_in;
        r_stage <= '0;
        r_cnt   <= '0;
      end
      if (w_in_hs) begin
        r_stage <= {r_stage[6143-W:0], in_data};
        r_cnt   <= r_cnt + 10'd1;
      end
      if (r_state == CAPTURE) begin
        r_outbuf <= r_k ? il_cout : il_cout << 5088;
        r_cnt    <= '0;
      end
      if (w_out_hs) begin
        r_outbuf <= r_outbuf << W;
        r_cnt    <= r_cnt + 10'd1;
      end
    end
  end
endmodule

// File: doc/coder_interleaver_ctrl.md
Name: coder_interleaver_ctrl

Overview:
Sequencer wrapped around the combinational turbo-coder interleaver (cin/K_eq_6144/cout).
- Collects one code block of K = 1056 or 6144 bits from a W-bit streaming input into a staging register, and drives it onto the interleaver.
- Captures the interleaver result and streams it back out W bits per beat.
- Sits between the code-block segmenter and the turbo encoder's second constituent encoder.

Parameters:
- W, 8, stream beat width in bits; must divide 1056 and 6144 (legal values 8, 16, 32).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a block; sampled only in IDLE.
- k_eq_6144_in  in  1  block size for this block, sampled with start: 1 = 6144 bits, 0 = 1056 bits.
- in_data  in  W  input beat; MSB is the earliest bit.
- in_valid  in  1  input beat valid.
- in_ready  out  1  controller accepts an input beat.
- out_data  out  W  interleaved output beat; MSB is the earliest bit.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts an output beat.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse after the final output beat is accepted.
- il_cin  out  6144  to interleaver cin.
- il_k_eq_6144  out  1  to interleaver K_eq_6144.
- il_cout  in  6144  from interleaver cout.

Behaviour:
- Reset: state = IDLE. All outputs are 0, including il_cin and il_k_eq_6144. Staging register, output register, size register and beat counter are all cleared. Reset in any state, including mid-LOAD and mid-UNLOAD, aborts the block; no done pulse is produced.
- Block length: N = K/W beats (132 or 768 at W=8). Beat counter is 10 bits.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - on start: latch k_eq_6144_in into the size register, clear the staging register and counter, go to LOAD.
  - in_valid in IDLE is ignored.
- LOAD:
  - in_ready = 1 starting the cycle after start.
  - Each handshake (in_valid & in_ready): staging <= {staging[6143-W:0], in_data}, counter++.
  - After N beats the first beat sits at bits [K-1:K-W] and bits [6143:K] remain 0, matching the interleaver's bit layout.
  - On the Nth handshake: in_ready drops the next cycle, go to CAPTURE.
  - start is ignored.
- CAPTURE (exactly one cycle):
  - outbuf <= il_cout if K = 6144.
  - outbuf <= il_cout << 5088 if K = 1056, so the result is top-aligned.
  - Counter cleared, go to UNLOAD.
- UNLOAD:
  - out_valid = 1; out_data = outbuf[6143:6144-W].
  - On each handshake: outbuf shifts left by W, counter++.
  - out_data and out_valid hold stable while out_ready = 0.
  - On the Nth handshake: next cycle state = IDLE, busy = 0, done = 1 for one cycle. start is accepted in that same cycle, so back-to-back blocks are possible.
- Interleaver drive: il_cin = staging register and il_k_eq_6144 = size register, both directly from registers. Both are stable from the end of LOAD through CAPTURE; the interleaver path is given one full clock period.
- Latency:
  - start at cycle t gives in_ready at t+1.
  - last input handshake at cycle n gives out_valid at n+2.
  - Minimum block time: N + 1 + N + 1 cycles from the first in_ready.
- start asserted outside IDLE (including the done cycle, which is IDLE) follows the IDLE rule above; in every non-IDLE state it has no effect.

Test Plan:
1. Reset and idle: reset 2 cycles; then in_valid = 1 with no start -> in_ready, out_valid, busy and done stay 0, il_cin = 0, for 20 cycles.
2. K = 1056 zero block: start with k = 0, 132 zero beats -> il_k_eq_6144 = 0; out_valid 2 cycles after the last beat; 132 beats of 0x00; done pulses once; busy falls with done.
3. K = 6144 random block: start with k = 1, 768 random beats, out_ready = 1 -> il_cin[6143:6136] equals the first beat; all 768 output beats match the bit-reversed-stream golden interleaver model (QPP f1 = 263, f2 = 480); exactly 768 beats.
4. K = 1056 random block with random in_valid/out_ready backpressure (50%) -> output matches the golden model (f1 = 17, f2 = 66); out_data never changes while out_valid & !out_ready; il_cin[6143:1056] = 0.
5. Robustness: start pulsed during LOAD and UNLOAD -> no effect on the size register or counter; reset asserted at beat 300 of a 6144 load -> next cycle all outputs are 0, and a following 1056 block is produced correctly with no stale bits.
6. Back-to-back: second start in the done cycle with a size change 6144 -> 1056 -> in_ready one cycle later; second output is correct; two done pulses total.
